// File: rtl/approx_mult_seq_pkg.sv
// approx_mult_pkg: shared constants for the sequential approximate multiplier.
// Holds the nibble-multiplier mode codes, the FSM state encoding and a helper
// that folds the reserved mode code onto exact mode.
package approx_mult_pkg;

   // Nibble multiplier modes; code 3 is reserved and behaves as exact
   localparam logic [1:0] MODE_EXACT = 2'd0;
   localparam logic [1:0] MODE_LSBT  = 2'd1;
   localparam logic [1:0] MODE_OPT   = 2'd2;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic logic [1:0] sanitize_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_EXACT : m;
   endfunction

endpackage

// File: rtl/approx_mult_seq_if.sv
// approx_mult_seq_if: operand/result handshake bundle for approx_mult_seq.
//   in_valid/in_ready/a/b/mode : operand channel (source -> multiplier)
//   out_valid/out_ready/result : result channel (multiplier -> sink)
//   busy                       : multiplier is iterating nibble pairs
// modport master is the environment (source + sink), modport slave the multiplier.
// W must match the W parameter of the multiplier it is bound to.
interface approx_mult_seq_if #(
   parameter int W = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [1:0]     mode;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] result;
   logic           busy;

   modport master (
      output in_valid, a, b, mode, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, a, b, mode, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/approx_mult_seq_nib4_mul_cfg.sv
// nib4_mul_cfg: configurable 4x4 -> 8 nibble multiplier, purely combinational.
//   x, y : unsigned nibbles
//   mode : 0 exact, 1 drop two product LSBs, 2 clear operand LSBs, 3 exact
//   r    : 8-bit (possibly approximate) product, never above x*y
module nib4_mul_cfg
   import approx_mult_pkg::*;
(
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic [1:0] mode,
   output logic [7:0] r
);

   logic [7:0] exact_p;
   logic [7:0] trunc_p;

   assign exact_p = {4'b0000, x} * {4'b0000, y};
   assign trunc_p = {4'b0000, x & 4'hE} * {4'b0000, y & 4'hE};

   always_comb begin
      r = exact_p;
      case (mode)
         MODE_LSBT: r = {exact_p[7:2], 2'b00};
         MODE_OPT:  r = trunc_p;
         default:   r = exact_p;
      endcase
   end

endmodule

// File: rtl/approx_mult_seq.sv
// approx_mult_seq: resource-shared approximate W x W -> 2W unsigned multiplier.
// One nib4_mul_cfg instance is stepped over all (W/4)^2 nibble pairs, one pair
// per cycle, and the partial products are shift-added into a 2W accumulator.
// Pairs with i+j < APPROX_K use the requested mode, the rest are exact.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : approx_mult_seq_if.slave (operand and result handshakes, busy)
// in_ready depends combinationally on out_ready; the sink must not feed
// in_ready back into out_ready.
module approx_mult_seq
   import approx_mult_pkg::*;
#(
   parameter int W        = 8,
   parameter int APPROX_K = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   approx_mult_seq_if.slave bus
);

   localparam int N  = W / 4;
   localparam int NN = N * N;
   localparam int IW = (NN > 1) ? $clog2(NN) : 1;
   localparam logic [IW-1:0] N_L      = IW'(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

   logic [1:0]     state;
   logic [IW-1:0]  idx;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [1:0]     mode_q;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] result_q;
   logic           out_valid_q;

   logic           in_ready;
   logic           accept;
   logic [IW-1:0]  i_sel;
   logic [IW-1:0]  j_sel;
   logic [IW:0]    sh_sum;
   logic [W-1:0]   a_sh;
   logic [W-1:0]   b_sh;
   logic           pair_approx;
   logic [1:0]     pair_mode;
   logic [7:0]     p;
   logic [2*W-1:0] addend;
   logic [2*W-1:0] acc_next;

   assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   // idx walks a-nibbles fastest: i = idx % N selects a, j = idx / N selects b
   assign i_sel  = idx % N_L;
   assign j_sel  = idx / N_L;
   assign sh_sum = {1'b0, i_sel} + {1'b0, j_sel};
   assign a_sh   = a_q >> {i_sel, 2'b00};
   assign b_sh   = b_q >> {j_sel, 2'b00};

   // Only low-significance pairs may be approximated; the rest stay exact
   assign pair_approx = (int'(i_sel) + int'(j_sel)) < APPROX_K;
   assign pair_mode   = pair_approx ? mode_q : MODE_EXACT;

   nib4_mul_cfg u_nib4 (
      .x    (a_sh[3:0]),
      .y    (b_sh[3:0]),
      .mode (pair_mode),
      .r    (p)
   );

   // Each approximate partial product is <= its exact one, so 2W bits never overflow
   assign addend   = {{(2*W-8){1'b0}}, p} << {sh_sum, 2'b00};
   assign acc_next = acc + addend;

   // Sequencer: accept in IDLE (or DONE while the result is being taken),
   // iterate all pairs in BUSY, then hold the result in DONE until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= MODE_EXACT;
         acc         <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if ((state == ST_DONE) && bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
               if (accept) begin
                  a_q    <= bus.a;
                  b_q    <= bus.b;
                  mode_q <= sanitize_mode(bus.mode);
                  acc    <= '0;
                  idx    <= '0;
                  state  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               acc <= acc_next;
               idx <= idx + IW'(1);
               if (idx == LAST_IDX) begin
                  state       <= ST_DONE;
                  result_q    <= acc_next;
                  out_valid_q <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.busy      = (state == ST_BUSY);

endmodule

// File: tb/tb_approx_mult_seq.sv
// tb_approx_mult_seq: self-checking bench for approx_mult_seq.
// Three instances: W=8/K=1 (directed + random), W=16/K=0 and W=16/K=3 (random,
// driven identically). A behavioural model computes each product as a plain sum
// of nibble partial products and tracks when each handshake output must be high.
module tb_approx_mult_seq;
   import approx_mult_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   approx_mult_seq_if #(.W(8))  if8 ();
   approx_mult_seq_if #(.W(16)) i16a ();
   approx_mult_seq_if #(.W(16)) i16b ();

   approx_mult_seq #(.W(8),  .APPROX_K(1)) dut8   (.clk(clk), .rst_n(rst_n), .bus(if8));
   approx_mult_seq #(.W(16), .APPROX_K(0)) dut16a (.clk(clk), .rst_n(rst_n), .bus(i16a));
   approx_mult_seq #(.W(16), .APPROX_K(3)) dut16b (.clk(clk), .rst_n(rst_n), .bus(i16b));

   int checksTotal  = 0;
   int checksPassed = 0;

   // Model state per instance (at most one operation in flight each)
   int          wOf[3] = '{8, 16, 16};
   int          kOf[3] = '{1, 0, 3};
   bit          pending[3];
   int          cnt[3];
   logic [63:0] expRes[3];
   logic [63:0] expA[3];
   logic [63:0] expB[3];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checksTotal++;
      if (actual === expected) checksPassed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Product as the sum of nibble partial products, each approximated by its rule
   function automatic logic [63:0] approxModel(input logic [63:0] av, input logic [63:0] bv,
                                               input logic [1:0] mv, input int w, input int k);
      logic [63:0] sum;
      int n, m, x, y, p;
      sum = 0;
      n   = w / 4;
      m   = (mv == 2'd3) ? 0 : int'(mv);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < n; j++) begin
            x = int'((av >> (4 * i)) & 64'hF);
            y = int'((bv >> (4 * j)) & 64'hF);
            if ((i + j) < k && m == 1)      p = (x * y) & ~3;
            else if ((i + j) < k && m == 2) p = (x & 14) * (y & 14);
            else                            p = x * y;
            sum += 64'(p) << (4 * (i + j));
         end
      end
      return sum;
   endfunction

   task automatic monitorStep(input int d, input logic rstn, input logic iv, input logic ir,
                              input logic [63:0] av, input logic [63:0] bv, input logic [1:0] mv,
                              input logic ov, input logic orr, input logic [63:0] res, input logic bsy);
      int nn;
      logic done, expIr, handoff, accept;
      string tag;
      nn  = (wOf[d] / 4) * (wOf[d] / 4);
      tag = $sformatf("d%0d", d);
      if (!rstn) begin
         checkOutput({tag, " reset in_ready"}, 64'(ir), 64'd1);
         checkOutput({tag, " reset out_valid"}, 64'(ov), 64'd0);
         checkOutput({tag, " reset busy"}, 64'(bsy), 64'd0);
         checkOutput({tag, " reset result"}, res, 64'd0);
         pending[d] = 1'b0;
         cnt[d]     = 0;
      end else begin
         done  = pending[d] && (cnt[d] >= nn);
         expIr = !pending[d] || (done && orr);
         checkOutput({tag, " in_ready"}, 64'(ir), 64'(expIr));
         checkOutput({tag, " out_valid"}, 64'(ov), 64'(done));
         checkOutput({tag, " busy"}, 64'(bsy), 64'(pending[d] && !done));
         if (done) checkOutput({tag, " result"}, res, expRes[d]);
         handoff = done && orr;
         accept  = iv && expIr;
         if (handoff) begin
            checkOutput({tag, " result <= a*b"}, 64'(res <= expA[d] * expB[d]), 64'd1);
            if (d == 1) checkOutput({tag, " all-exact product"}, res, expA[d] * expB[d]);
            pending[d] = 1'b0;
         end
         if (accept) begin
            pending[d] = 1'b1;
            cnt[d]     = 0;
            expRes[d]  = approxModel(av, bv, mv, wOf[d], kOf[d]);
            expA[d]    = av;
            expB[d]    = bv;
         end else if (pending[d] && cnt[d] < nn) begin
            cnt[d]++;
         end
      end
   endtask

   // Single compare process, sampling on the falling edge
   always @(negedge clk) begin
      monitorStep(0, rst_n, if8.in_valid, if8.in_ready, 64'(if8.a), 64'(if8.b), if8.mode,
                  if8.out_valid, if8.out_ready, 64'(if8.result), if8.busy);
      monitorStep(1, rst_n, i16a.in_valid, i16a.in_ready, 64'(i16a.a), 64'(i16a.b), i16a.mode,
                  i16a.out_valid, i16a.out_ready, 64'(i16a.result), i16a.busy);
      monitorStep(2, rst_n, i16b.in_valid, i16b.in_ready, 64'(i16b.a), 64'(i16b.b), i16b.mode,
                  i16b.out_valid, i16b.out_ready, 64'(i16b.result), i16b.busy);
   end

   task automatic driveInputs(input int d, input logic iv, input logic [15:0] av, input logic [15:0] bv,
                              input logic [1:0] mv, input logic orr);
      if (d == 0) begin
         if8.in_valid = iv; if8.a = av[7:0]; if8.b = bv[7:0]; if8.mode = mv; if8.out_ready = orr;
      end else begin
         i16a.in_valid = iv; i16a.a = av; i16a.b = bv; i16a.mode = mv; i16a.out_ready = orr;
         i16b.in_valid = iv; i16b.a = av; i16b.b = bv; i16b.mode = mv; i16b.out_ready = orr;
      end
   endtask

   task automatic setOutReady(input int d, input logic orr);
      if (d == 0) if8.out_ready = orr;
      else begin
         i16a.out_ready = orr;
         i16b.out_ready = orr;
      end
   endtask

   function automatic logic inReadyOf(input int d);
      return (d == 0) ? if8.in_ready : (i16a.in_ready & i16b.in_ready);
   endfunction

   function automatic logic outValidOf(input int d);
      return (d == 0) ? if8.out_valid : (i16a.out_valid & i16b.out_valid);
   endfunction

   // Present operands until accepted; returns just after the accept edge
   task automatic applyStimulus(input int d, input logic [15:0] av, input logic [15:0] bv, input logic [1:0] mv);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      driveInputs(d, 1'b1, av, bv, mv, 1'b1);
      for (int c = 0; c < 60 && !ok; c++) begin
         @(negedge clk);
         ok = inReadyOf(d);
      end
      @(posedge clk); #1;
      driveInputs(d, 1'b0, 16'($urandom), 16'($urandom), 2'($urandom), 1'b1);
      if (!ok) checkOutput($sformatf("d%0d accept timeout", d), 64'd0, 64'd1);
   endtask

   // Wait for out_valid; checks the number of edges since the accept edge
   task automatic waitResult(input int d);
      int nn, lat;
      bit seen;
      nn   = (d == 0) ? 4 : 16;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat <= nn + 20) begin
         @(negedge clk);
         if (outValidOf(d)) seen = 1'b1;
         else lat++;
      end
      checkOutput($sformatf("d%0d latency", d), seen ? 64'(lat) : 64'd999, 64'(nn));
   endtask

   task automatic directedCase(input string name, input logic [7:0] av, input logic [7:0] bv,
                               input logic [1:0] mv, input logic [15:0] expected);
      applyStimulus(0, {8'h00, av}, {8'h00, bv}, mv);
      waitResult(0);
      checkOutput(name, 64'(if8.result), 64'(expected));
   endtask

   task automatic randomRun(input int d, input int count);
      for (int k = 0; k < count; k++) begin
         applyStimulus(d, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
         setOutReady(d, 1'($urandom_range(0, 1)));
         waitResult(d);
         if ((d == 0 && !if8.out_ready) || (d != 0 && !i16a.out_ready))
            repeat ($urandom_range(0, 4)) @(posedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      driveInputs(0, 1'b0, 16'h0, 16'h0, MODE_EXACT, 1'b1);
      driveInputs(1, 1'b0, 16'h0, 16'h0, MODE_EXACT, 1'b1);

      // Hand-computed values pinning the model
      checkOutput("model FFxFF exact", approxModel(64'hFF, 64'hFF, 2'd0, 8, 1), 64'd65025);
      checkOutput("model 0Fx0F lsbt", approxModel(64'h0F, 64'h0F, 2'd1, 8, 1), 64'd224);
      checkOutput("model 13x11 opt", approxModel(64'h13, 64'h11, 2'd2, 8, 1), 64'd320);
      checkOutput("model 0Fx0F opt", approxModel(64'h0F, 64'h0F, 2'd2, 8, 1), 64'd196);
      checkOutput("model W16 K3 lsbt", approxModel(64'hFF, 64'hFF, 2'd1, 16, 3), 64'd64736);
      checkOutput("model W16 K0 opt", approxModel(64'hFF, 64'hFF, 2'd2, 16, 0), 64'd65025);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      directedCase("exact FFxFF", 8'hFF, 8'hFF, MODE_EXACT, 16'hFE01);
      directedCase("lsbt 0Fx0F", 8'h0F, 8'h0F, MODE_LSBT, 16'd224);
      directedCase("exact 0Fx0F", 8'h0F, 8'h0F, MODE_EXACT, 16'd225);
      directedCase("opt 13x11", 8'h13, 8'h11, MODE_OPT, 16'd320);
      directedCase("opt 0Fx0F", 8'h0F, 8'h0F, MODE_OPT, 16'd196);
      directedCase("mode3 as exact", 8'h0F, 8'h0F, 2'd3, 16'd225);

      // Backpressure in DONE, then hand-off and new accept on the same edge
      applyStimulus(0, 16'h0F, 16'h0F, MODE_LSBT);
      setOutReady(0, 1'b0);
      waitResult(0);
      @(posedge clk); #1;
      driveInputs(0, 1'b1, 16'hAA, 16'hBB, MODE_EXACT, 1'b0);
      repeat (5) begin
         @(negedge clk);
         checkOutput("bp result held", 64'(if8.result), 64'd224);
         checkOutput("bp out_valid held", 64'(if8.out_valid), 64'd1);
         checkOutput("bp in_ready low", 64'(if8.in_ready), 64'd0);
      end
      @(posedge clk); #1;
      driveInputs(0, 1'b1, 16'd3, 16'd5, MODE_EXACT, 1'b1);
      @(negedge clk);
      checkOutput("b2b in_ready", 64'(if8.in_ready), 64'd1);
      checkOutput("b2b first result", 64'(if8.result), 64'd224);
      @(posedge clk); #1;
      driveInputs(0, 1'b0, 16'h0, 16'h0, MODE_EXACT, 1'b1);
      waitResult(0);
      checkOutput("b2b second result", 64'(if8.result), 64'd15);

      // Reset while BUSY at idx 2
      applyStimulus(0, 16'hFF, 16'hFF, MODE_EXACT);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst busy", 64'(if8.busy), 64'd0);
      checkOutput("rst in_ready", 64'(if8.in_ready), 64'd1);
      checkOutput("rst out_valid", 64'(if8.out_valid), 64'd0);
      checkOutput("rst result", 64'(if8.result), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         checkOutput("no stale out_valid", 64'(if8.out_valid), 64'd0);
      end
      directedCase("after reset 3x5", 8'd3, 8'd5, MODE_EXACT, 16'd15);

      randomRun(0, 200);
      randomRun(1, 1000);

      repeat (3) @(posedge clk);
      $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
